// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared types, default widths and helpers for the L2 port arbiter.
// Optional feature macro: L2_ARB_PERF_CNT_EN (sat_inc is used only by its counters).
package l2_arb_pkg;
    localparam int L2_ADDR_W = 30;
    localparam int L2_LINE_W = 128;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_t;
    typedef enum logic [1:0] {NONE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} grant_t;
    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
        return c + {15'd0, en & ~&c};
    endfunction
endpackage

// File: rtl/l2_arb_rr_pick.sv
// l2_arb_rr_pick: combinational 2-way round-robin picker.
// Ports:
//   i_req_i, i_req_d : requests from I and D
//   i_rr_ptr         : favoured requester on conflict (1 = D, 0 = I)
//   o_grant          : chosen requester (NONE when idle)
//   o_rr_ptr         : pointer after this pick (toggles only on conflict)
module l2_arb_rr_pick
    import l2_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   i_req_d,
    input  logic   i_rr_ptr,
    output grant_t o_grant,
    output logic   o_rr_ptr
);
    logic w_both;
    assign w_both   = i_req_i & i_req_d;
    assign o_grant  = w_both ? (i_rr_ptr ? GNT_D : GNT_I) : i_req_d ? GNT_D : i_req_i ? GNT_I : NONE;
    assign o_rr_ptr = w_both ? ~i_rr_ptr : i_rr_ptr;
endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares one L2 request port between the I and D L1 caches.
// Ports:
//   clk, proc_reset_n          : clock, async active-low reset
//   perf_cnt                   : {lock_hits, conflict_cycles, d_grants, i_grants}
//                                (only when L2_ARB_PERF_CNT_EN is defined)
//   i_* / d_*                  : per-L1 request (read/write/addr/wdata) and
//                                response (rdata/ready/stall)
//   l2_read/write/addr/wdata   : request to L2, driven only in BUSY
//   l2_rdata/ready/stall       : response from L2
// Optional feature macro: L2_ARB_PERF_CNT_EN.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W       = L2_ADDR_W,
    parameter int LINE_W       = L2_LINE_W,
    parameter bit RESET_PRIO_D = 1'b1
) (
    input  logic              clk,
    input  logic              proc_reset_n,
`ifdef L2_ARB_PERF_CNT_EN
    output logic [63:0]       perf_cnt,
`endif
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              i_stall,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_ready,
    input  logic              l2_stall
);
    state_t r_state;
    grant_t r_grant;
    logic   r_rr_ptr;
    logic   r_last_op_wr;
    logic   r_op_wr;
    grant_t w_pick;
    logic   w_pick_ptr;
    logic   w_i_req, w_d_req, w_lock, w_pick_wr, w_lock_wr, w_busy, w_sel_d;

    assign w_i_req = i_read | i_write;
    assign w_d_req = d_read | d_write;

    l2_arb_rr_pick u_pick (
        .i_req_i (w_i_req),
        .i_req_d (w_d_req),
        .i_rr_ptr(r_rr_ptr),
        .o_grant (w_pick),
        .o_rr_ptr(w_pick_ptr)
    );

    // Writeback just finished and the same L1 now asks for its allocate read.
    assign w_lock    = r_last_op_wr & ((r_grant == GNT_I && i_read) || (r_grant == GNT_D && d_read));
    // Write wins when read and write are both raised.
    assign w_pick_wr = (w_pick == GNT_D) ? d_write : i_write;
    assign w_lock_wr = (r_grant == GNT_D) ? d_write : i_write;

    // The operation type is latched at grant so a request dropped mid-BUSY still completes.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state      <= IDLE;
            r_grant      <= NONE;
            r_rr_ptr     <= RESET_PRIO_D;
            r_last_op_wr <= 1'b0;
            r_op_wr      <= 1'b0;
        end else if (!l2_stall) begin
            case (r_state)
                IDLE: if (w_pick != NONE) begin
                    r_grant  <= w_pick;
                    r_rr_ptr <= w_pick_ptr;
                    r_op_wr  <= w_pick_wr;
                    r_state  <= BUSY;
                end
                BUSY: if (l2_ready) begin
                    r_last_op_wr <= r_op_wr;
                    r_state      <= DRAIN;
                end
                DRAIN: if (w_lock) begin
                    r_op_wr <= w_lock_wr;
                    r_state <= BUSY;
                end else if (w_pick != NONE) begin
                    r_grant  <= w_pick;
                    r_rr_ptr <= w_pick_ptr;
                    r_op_wr  <= w_pick_wr;
                    r_state  <= BUSY;
                end else begin
                    r_grant <= NONE;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_busy   = (r_state == BUSY) && (r_grant != NONE);
    assign w_sel_d  = (r_grant == GNT_D);
    assign l2_read  = w_busy & ~r_op_wr;
    assign l2_write = w_busy & r_op_wr;
    assign l2_addr  = w_busy ? (w_sel_d ? d_addr : i_addr) : '0;
    assign l2_wdata = w_busy ? (w_sel_d ? d_wdata : i_wdata) : '0;
    assign i_ready  = w_busy & ~w_sel_d & l2_ready & ~l2_stall;
    assign d_ready  = w_busy & w_sel_d & l2_ready & ~l2_stall;
    assign i_rdata  = l2_rdata;
    assign d_rdata  = l2_rdata;
    assign i_stall  = l2_stall;
    assign d_stall  = l2_stall;

`ifdef L2_ARB_PERF_CNT_EN
    logic [15:0] r_i_grants, r_d_grants, r_conflict, r_lock_hits;
    logic        w_pick_en, w_lock_hit, w_new_i, w_new_d;
    assign w_lock_hit = (r_state == DRAIN) && w_lock;
    assign w_pick_en  = (r_state == IDLE) || ((r_state == DRAIN) && !w_lock);
    assign w_new_i    = (w_pick_en && w_pick == GNT_I) || (w_lock_hit && r_grant == GNT_I);
    assign w_new_d    = (w_pick_en && w_pick == GNT_D) || (w_lock_hit && r_grant == GNT_D);
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_i_grants  <= '0;
            r_d_grants  <= '0;
            r_conflict  <= '0;
            r_lock_hits <= '0;
        end else if (!l2_stall) begin
            r_i_grants  <= sat_inc(r_i_grants, w_new_i);
            r_d_grants  <= sat_inc(r_d_grants, w_new_d);
            r_conflict  <= sat_inc(r_conflict, w_i_req & w_d_req);
            r_lock_hits <= sat_inc(r_lock_hits, w_lock_hit);
        end
    end
    assign perf_cnt = {r_lock_hits, r_conflict, r_d_grants, r_i_grants};
`endif
endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed self-checking bench for l2_port_arbiter.
module tb_l2_port_arbiter;
    import l2_arb_pkg::*;
    logic         clk = 1'b0;
    logic         proc_reset_n = 1'b0;
    logic         i_read = 0, i_write = 0, d_read = 0, d_write = 0;
    logic [29:0]  i_addr = '0, d_addr = '0;
    logic [127:0] i_wdata = '0, d_wdata = '0, l2_rdata = '0;
    logic         l2_ready = 0, l2_stall = 0;
    logic [127:0] i_rdata, d_rdata, l2_wdata;
    logic [29:0]  l2_addr;
    logic         i_ready, i_stall, d_ready, d_stall, l2_read, l2_write;
`ifdef L2_ARB_PERF_CNT_EN
    logic [63:0]  perf_cnt;
`endif
    int total = 0;
    int bad = 0;
    int n_i_rdy = 0;
    int base;

    l2_port_arbiter dut (
        .clk         (clk),
        .proc_reset_n(proc_reset_n),
`ifdef L2_ARB_PERF_CNT_EN
        .perf_cnt    (perf_cnt),
`endif
        .i_read      (i_read),
        .i_write     (i_write),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_rdata     (i_rdata),
        .i_ready     (i_ready),
        .i_stall     (i_stall),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ready     (d_ready),
        .d_stall     (d_stall),
        .l2_read     (l2_read),
        .l2_write    (l2_write),
        .l2_addr     (l2_addr),
        .l2_wdata    (l2_wdata),
        .l2_rdata    (l2_rdata),
        .l2_ready    (l2_ready),
        .l2_stall    (l2_stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (i_ready) n_i_rdy++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        proc_reset_n = 1'b0;
        {i_read, i_write, d_read, d_write, l2_ready, l2_stall} = '0;
        tick();
        tick();
        proc_reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #1;
        chk("rst_l2_read", l2_read, 0);
        chk("rst_i_ready", i_ready, 0);
        do_reset();
        chk("rst_state", dut.r_state, IDLE);
        chk("rst_grant", dut.r_grant, NONE);
        chk("rst_rr_ptr", dut.r_rr_ptr, 1);

        // I alone reads 0x100, L2 ready after 3 cycles
        base = n_i_rdy;
        i_read = 1; i_addr = 30'h0000100;
        #1;
        chk("s1_no_req_same_cycle", l2_read, 0);
        tick();
        chk("s1_l2_read", l2_read, 1);
        chk("s1_l2_addr", l2_addr, 30'h0000100);
        tick();
        chk("s1_i_ready_early", i_ready, 0);
        tick();
        l2_ready = 1; l2_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        #1;
        chk("s1_i_ready", i_ready, 1);
        chk("s1_d_ready", d_ready, 0);
        chk("s1_d_rdata", d_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        tick();
        l2_ready = 0; i_read = 0;
        #1;
        chk("s1_drain_l2_read", l2_read, 0);
        tick();
        chk("s1_idle", dut.r_state, IDLE);
        chk("s1_i_ready_once", n_i_rdy - base, 1);

        // Conflict: D first, then I after DRAIN, next conflict I first
        i_read = 1; i_addr = 30'h0000111; d_read = 1; d_addr = 30'h0000222;
        tick();
        chk("s2_first_d", l2_addr, 30'h0000222);
        l2_ready = 1;
        #1;
        chk("s2_d_ready", d_ready, 1);
        chk("s2_i_ready_0", i_ready, 0);
        tick();
        l2_ready = 0; d_read = 0;
        #1;
        chk("s2_drain_gap", l2_read, 0);
        tick();
        chk("s2_then_i", l2_addr, 30'h0000111);
        l2_ready = 1;
        #1;
        chk("s2_i_ready", i_ready, 1);
        tick();
        l2_ready = 0; i_read = 0;
        tick();
        chk("s2_idle", dut.r_state, IDLE);
        i_read = 1; d_read = 1;
        tick();
        chk("s2_next_conflict_i", l2_addr, 30'h0000111);
        l2_ready = 1;
        tick();
        l2_ready = 0; i_read = 0; d_read = 0;
        tick();

        // Locked writeback -> allocate on D while I keeps requesting
        do_reset();
        d_write = 1; d_addr = 30'h0ABCDE0;
        d_wdata = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        i_read = 1; i_addr = 30'h0000200;
        tick();
        chk("s3_wb_write", l2_write, 1);
        chk("s3_wb_read0", l2_read, 0);
        chk("s3_wb_addr", l2_addr, 30'h0ABCDE0);
        chk("s3_wb_wdata", l2_wdata, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
        l2_ready = 1;
        #1;
        chk("s3_wb_ready", d_ready, 1);
        tick();
        l2_ready = 0; d_write = 0; d_read = 1; d_addr = 30'h0123450;
        tick();
        chk("s3_lock_read", l2_read, 1);
        chk("s3_lock_addr", l2_addr, 30'h0123450);
        l2_ready = 1;
        #1;
        chk("s3_lock_d_ready", d_ready, 1);
        chk("s3_lock_i_wait", i_ready, 0);
        tick();
        l2_ready = 0; d_read = 0;
        tick();
        chk("s3_i_after", l2_addr, 30'h0000200);
`ifdef L2_ARB_PERF_CNT_EN
        chk("s3_lock_hits", perf_cnt[63:48], 16'd1);
`endif
        l2_ready = 1;
        tick();
        l2_ready = 0; i_read = 0;
        tick();

        // Stall holds completion for 5 cycles
        i_read = 1; i_addr = 30'h0000300;
        tick();
        l2_stall = 1; l2_ready = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("s4_stall_ready", i_ready, 0);
            chk("s4_stall_pass", i_stall, 1);
            tick();
            chk("s4_stall_state", dut.r_state, BUSY);
        end
        l2_stall = 0;
        #1;
        chk("s4_ready_after", i_ready, 1);
        tick();
        l2_ready = 0; i_read = 0;
        tick();

        // Async reset mid-BUSY
        d_write = 1; d_addr = 30'h0000400;
        tick();
        chk("s5_busy_write", l2_write, 1);
        proc_reset_n = 0;
        #1;
        chk("s5_async_write", l2_write, 0);
        chk("s5_async_read", l2_read, 0);
        d_write = 0;
        tick();
        proc_reset_n = 1;
        tick();
        chk("s5_idle", dut.r_state, IDLE);
        i_read = 1; i_addr = 30'h0000500;
        tick();
        chk("s5_regrant", l2_read, 1);
        l2_ready = 1;
        tick();
        l2_ready = 0; i_read = 0;
        tick();

        // Request dropped mid-BUSY still completes
        i_read = 1; i_addr = 30'h0000600;
        tick();
        i_read = 0;
        #1;
        chk("s6_hold_read", l2_read, 1);
        tick();
        chk("s6_hold_read2", l2_read, 1);
        l2_ready = 1;
        #1;
        chk("s6_i_ready", i_ready, 1);
        chk("s6_d_ready", d_ready, 0);
        tick();
        l2_ready = 0;
        tick();
        chk("s6_idle", dut.r_state, IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 cache request port between the instruction L1 (I) and the data L1 (D) in the pipelined MIPS core.
- Each L1 sees a private L2-style port: read/write/addr/128-bit wdata in, rdata/ready/stall out.
- Grants are round-robin. A writeback followed by its allocate read from the same L1 is kept atomic, so the other requester cannot slip in between them.

Parameters:
- ADDR_W, 30, word address width.
- LINE_W, 128, cache line width.
- RESET_PRIO_D, 1, requester favoured by the round-robin pointer after reset (1 = D, 0 = I).

Ports:
- clk  in  1  clock
- proc_reset_n  in  1  reset, asynchronous and active-low
- i_read, i_write  in  1 each  I-cache request
- i_addr  in  ADDR_W  I-cache address
- i_wdata  in  LINE_W  I-cache write line
- i_rdata  out  LINE_W  read line returned to I-cache
- i_ready  out  1  I-cache completion pulse
- i_stall  out  1  stall to I-cache
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready, d_stall  same as the i_ ports, for the D-cache
- l2_read, l2_write  out  1 each  request to L2
- l2_addr  out  ADDR_W  address to L2
- l2_wdata  out  LINE_W  write line to L2
- l2_rdata  in  LINE_W  read line from L2
- l2_ready  in  1  L2 completion
- l2_stall  in  1  L2 stall

Behaviour:
- Reset (async, proc_reset_n=0):
  - state=IDLE, grant=NONE, rr_ptr=RESET_PRIO_D, last_op_wr=0.
  - All l2_* request outputs and *_ready are 0 immediately.
- Request: a requester is requesting when read or write is 1. If read and write are both 1, write wins.
- States:
  - IDLE: if exactly one requester is requesting, grant it. If both are requesting, grant the one selected by rr_ptr, then toggle rr_ptr to the other. Go to BUSY next cycle. Otherwise stay in IDLE.
  - BUSY:
    - l2_read, l2_write, l2_addr and l2_wdata are a combinational mux of the granted port.
    - On l2_ready: pulse the granted port's *_ready combinationally in the same cycle, record last_op_wr = granted write, go to DRAIN.
  - DRAIN (1 cycle; the L1 updates its registered request during this cycle; l2_* request outputs are 0):
    - If last_op_wr=1 and the same requester now has read=1: keep the grant and go to BUSY (locked writeback→allocate).
    - Else if any requester is requesting: perform the IDLE arbitration and go to BUSY.
    - Else: go to IDLE.
- Outputs and stall:
  - l2_* request outputs are 0 whenever grant=NONE or state≠BUSY.
  - l2_rdata is broadcast unmodified to i_rdata and d_rdata.
  - *_ready is 1 only for the granted port, in BUSY, while l2_ready=1.
  - i_stall = d_stall = l2_stall.
  - While l2_stall=1, state, grant, rr_ptr and last_op_wr hold their values, and *_ready is forced to 0.
- Latency:
  - Request visible in IDLE at cycle N → l2 request outputs driven at N+1.
  - Back-to-back re-grant at the earliest after one DRAIN cycle.
- Boundary conditions:
  - A request that drops during BUSY without a preceding l2_ready still completes. The L2 is never abandoned, and the granted port's latched operation type is held.
  - A reset mid-transaction discards the transaction; the L1s are reset together with the arbiter.
- Width: no arithmetic on the datapath; addr and wdata pass through untouched.

Optional Feature:
- Macro: L2_ARB_PERF_CNT_EN.
- Defined:
  - Adds 16-bit saturating counters: i_grants, d_grants, conflict_cycles (both requesting while one waits) and lock_hits (locked re-grants).
  - Adds output port perf_cnt (64 bits, {lock_hits, conflict_cycles, d_grants, i_grants}).
  - Counters reset to 0 and freeze during l2_stall.
- Undefined: no counters and no perf_cnt port. Behaviour is otherwise identical.

Decomposition:
- Shared package l2_arb_pkg:
  - state encoding: IDLE=2'd0, BUSY=2'd1, DRAIN=2'd2
  - grant encoding: NONE=2'd0, GNT_I=2'd1, GNT_D=2'd2
  - default widths ADDR_W and LINE_W
- One natural sub-module: l2_arb_rr_pick, a combinational 2-way round-robin picker (inputs: requests and rr_ptr; outputs: grant and next rr_ptr). The FSM and mux stay in the top module.

Test Plan:
- Reset with rr_ptr favouring D; I alone reads 0x0000100, L2 ready after 3 cycles → l2_read=1 and l2_addr=0x0000100 one cycle after the request; i_ready pulses exactly once; d_ready stays 0; d_rdata equals l2_rdata.
- I and D read simultaneously from IDLE → D is served first; I is served after the DRAIN cycle; on the next conflict I is served first.
- D writeback to 0x0ABCDE0 with wdata=128'hDEAD…BEEF, then read 0x0123450, while I requests continuously → D's read is granted straight from DRAIN (locked); I waits; lock_hits=1 if L2_ARB_PERF_CNT_EN is defined.
- l2_stall=1 for 5 cycles while l2_ready=1 in BUSY → no *_ready pulse and state held; completion occurs once stall drops.
- proc_reset_n driven low mid-BUSY → l2_read and l2_write drop to 0 without waiting for a clock edge; after release, state=IDLE and the next request is granted normally.
- Requester drops read mid-BUSY before l2_ready → l2_read stays 1 until l2_ready; the ready pulse is still routed to that requester.
